// File: rtl/fpu_status_control_port_if.sv
// CPU I/O bus bundle for the FPU status/control port: decoder-side strobes in, registered read data and ack out.
interface fpu_status_control_port_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cs;
  logic                  data_m_access;
  logic                  data_m_wr_en;
  logic [1:0]            data_m_addr;
  logic [1:0]            data_m_bytesel;
  logic [DATA_WIDTH-1:0] data_m_data_in;
  logic [DATA_WIDTH-1:0] data_m_data_out;
  logic                  data_m_ack;

  modport master (
    output cs, data_m_access, data_m_wr_en, data_m_addr, data_m_bytesel, data_m_data_in,
    input  data_m_data_out, data_m_ack
  );

  modport slave (
    input  cs, data_m_access, data_m_wr_en, data_m_addr, data_m_bytesel, data_m_data_in,
    output data_m_data_out, data_m_ack
  );
endinterface

// File: rtl/fpu_status_control_port.sv
// FPU I/O port: sticky W1C exception status, R/W control and tag words, one-cycle ack,
// and a masked-exception interrupt request.
module fpu_status_control_port #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           NUM_EXC    = 6,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = DATA_WIDTH'(16'h037F),
  parameter logic [DATA_WIDTH-1:0] TAG_RESET  = DATA_WIDTH'(16'hFFFF)
) (
  input  logic                    clk,
  input  logic                    reset,
  fpu_status_control_port_if.slave bus,
  input  logic [DATA_WIDTH-1:0]   status_word_in,
  input  logic [NUM_EXC-1:0]      exc_pulse_in,
  input  logic                    fninit,
  output logic [DATA_WIDTH-1:0]   control_word_out,
  output logic [DATA_WIDTH-1:0]   tag_word_out,
  output logic                    irq_out
);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_TAG    = 2'd2;
  localparam int unsigned EXC_FIELD  = 6;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ack;
  logic [NUM_EXC-1:0]    r_sticky;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_tag;
  logic                  r_irq;

  logic                  w_access;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_es;
  logic [DATA_WIDTH-1:0] w_byte_mask;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_EXC-1:0]    w_sticky_nxt;
  logic [DATA_WIDTH-1:0] w_ctrl_nxt;
  logic [DATA_WIDTH-1:0] w_tag_nxt;

  // Access decode, read mux and next-state for the architectural registers
  always_comb begin
    w_access    = bus.cs & bus.data_m_access & ~r_ack;
    w_wr        = w_access & bus.data_m_wr_en;
    w_rd        = w_access & ~bus.data_m_wr_en;
    w_byte_mask = {{(DATA_WIDTH-8){bus.data_m_bytesel[1]}}, {8{bus.data_m_bytesel[0]}}};
    w_es        = |(r_sticky & ~r_ctrl[NUM_EXC-1:0]);

    // Status: live core bits, with exception field and ES replaced locally
    w_status                = status_word_in;
    w_status[7]             = w_es;
    w_status[EXC_FIELD-1:0] = EXC_FIELD'(r_sticky);

    w_rd_data = '0;
    case (bus.data_m_addr)
      ADDR_STATUS: w_rd_data = w_status;
      ADDR_CTRL:   w_rd_data = r_ctrl;
      ADDR_TAG:    w_rd_data = r_tag;
      default:     w_rd_data = '0;
    endcase

    // Exception events beat a same-cycle W1C so no event is ever lost
    w_sticky_nxt = r_sticky;
    if (w_wr && (bus.data_m_addr == ADDR_STATUS) && bus.data_m_bytesel[0]) begin
      w_sticky_nxt = w_sticky_nxt & ~bus.data_m_data_in[NUM_EXC-1:0];
    end
    w_sticky_nxt = w_sticky_nxt | exc_pulse_in;

    w_ctrl_nxt = r_ctrl;
    if (w_wr && (bus.data_m_addr == ADDR_CTRL)) begin
      w_ctrl_nxt = (r_ctrl & ~w_byte_mask) | (bus.data_m_data_in & w_byte_mask);
    end

    w_tag_nxt = r_tag;
    if (w_wr && (bus.data_m_addr == ADDR_TAG)) begin
      w_tag_nxt = (r_tag & ~w_byte_mask) | (bus.data_m_data_in & w_byte_mask);
    end

    if (fninit) begin
      w_sticky_nxt = '0;
      w_ctrl_nxt   = CTRL_RESET;
      w_tag_nxt    = TAG_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_ack    <= 1'b0;
      r_sticky <= '0;
      r_ctrl   <= CTRL_RESET;
      r_tag    <= TAG_RESET;
      r_irq    <= 1'b0;
    end else begin
      r_ack    <= w_access;
      if (w_rd) begin
        r_data <= w_rd_data;
      end
      r_sticky <= w_sticky_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_tag    <= w_tag_nxt;
      r_irq    <= w_es & ~r_ctrl[7];
    end
  end

  assign bus.data_m_data_out = r_data;
  assign bus.data_m_ack      = r_ack;
  assign control_word_out    = r_ctrl;
  assign tag_word_out        = r_tag;
  assign irq_out             = r_irq;

endmodule

// File: tb/tb_fpu_status_control_port.sv
// Bench for fpu_status_control_port: directed scenarios plus random traffic against a
// register-level reference model of the port.
module tb_fpu_status_control_port;

  logic        clk;
  logic        reset;
  logic [15:0] status_word_in;
  logic [5:0]  exc_pulse_in;
  logic        fninit;
  logic [15:0] control_word_out;
  logic [15:0] tag_word_out;
  logic        irq_out;

  int n_vec;
  int n_err;

  // Reference state
  logic        m_ack;
  logic [15:0] m_data;
  logic [5:0]  m_sticky;
  logic [15:0] m_ctrl;
  logic [15:0] m_tag;
  logic        m_irq;

  fpu_status_control_port_if #(.DATA_WIDTH(16)) bus_if ();

  fpu_status_control_port #(
    .DATA_WIDTH(16),
    .NUM_EXC   (6),
    .CTRL_RESET(16'h037F),
    .TAG_RESET (16'hFFFF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus_if.slave),
    .status_word_in  (status_word_in),
    .exc_pulse_in    (exc_pulse_in),
    .fninit          (fninit),
    .control_word_out(control_word_out),
    .tag_word_out    (tag_word_out),
    .irq_out         (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] bs);
    logic [15:0] mask;
    mask = {(bs[1] ? 8'hFF : 8'h00), (bs[0] ? 8'hFF : 8'h00)};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // One clock: predict from pre-edge inputs, advance, compare every output
  task automatic step();
    logic        acc;
    logic        es;
    logic [15:0] rd;
    logic [15:0] d;
    logic        n_ack;
    logic [15:0] n_data;
    logic [5:0]  n_sticky;
    logic [15:0] n_ctrl;
    logic [15:0] n_tag;
    logic        n_irq;
    acc = bus_if.cs & bus_if.data_m_access & ~m_ack;
    d   = bus_if.data_m_data_in;
    es  = |(m_sticky & ~m_ctrl[5:0]);
    case (bus_if.data_m_addr)
      2'd0:    rd = (status_word_in & 16'hFF40) | (es ? 16'h0080 : 16'h0000) | {10'd0, m_sticky};
      2'd1:    rd = m_ctrl;
      2'd2:    rd = m_tag;
      default: rd = 16'h0000;
    endcase
    n_ack    = acc;
    n_data   = (acc && !bus_if.data_m_wr_en) ? rd : m_data;
    n_sticky = m_sticky;
    n_ctrl   = m_ctrl;
    n_tag    = m_tag;
    if (acc && bus_if.data_m_wr_en) begin
      if (bus_if.data_m_addr == 2'd0 && bus_if.data_m_bytesel[0]) n_sticky = m_sticky & ~d[5:0];
      if (bus_if.data_m_addr == 2'd1) n_ctrl = merge(m_ctrl, d, bus_if.data_m_bytesel);
      if (bus_if.data_m_addr == 2'd2) n_tag = merge(m_tag, d, bus_if.data_m_bytesel);
    end
    n_sticky = n_sticky | exc_pulse_in;
    if (fninit) begin
      n_sticky = 6'd0;
      n_ctrl   = 16'h037F;
      n_tag    = 16'hFFFF;
    end
    n_irq = es & ~m_ctrl[7];
    if (reset) begin
      n_ack = 1'b0; n_data = 16'h0; n_sticky = 6'd0;
      n_ctrl = 16'h037F; n_tag = 16'hFFFF; n_irq = 1'b0;
    end
    @(posedge clk);
    m_ack = n_ack; m_data = n_data; m_sticky = n_sticky;
    m_ctrl = n_ctrl; m_tag = n_tag; m_irq = n_irq;
    #1;
    check("ack",  {15'd0, bus_if.data_m_ack}, {15'd0, m_ack});
    check("data", bus_if.data_m_data_out, m_data);
    check("ctrl", control_word_out, m_ctrl);
    check("tag",  tag_word_out, m_tag);
    check("irq",  {15'd0, irq_out}, {15'd0, m_irq});
    @(negedge clk);
  endtask

  task automatic idle();
    bus_if.cs = 1'b0;
    bus_if.data_m_access = 1'b0;
    step();
  endtask

  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [1:0] bs,
                        input logic [15:0] d);
    bus_if.cs             = 1'b1;
    bus_if.data_m_access  = 1'b1;
    bus_if.data_m_wr_en   = wr;
    bus_if.data_m_addr    = a;
    bus_if.data_m_bytesel = bs;
    bus_if.data_m_data_in = d;
    step();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    status_word_in = 16'h0;
    exc_pulse_in = 6'd0;
    fninit = 1'b0;
    bus_if.cs = 1'b0;
    bus_if.data_m_access = 1'b0;
    bus_if.data_m_wr_en = 1'b0;
    bus_if.data_m_addr = 2'd0;
    bus_if.data_m_bytesel = 2'd0;
    bus_if.data_m_data_in = 16'h0;

    // Reset state
    step();
    step();
    check("rst_ack",  {15'd0, bus_if.data_m_ack}, 16'h0000);
    check("rst_data", bus_if.data_m_data_out, 16'h0000);
    check("rst_ctrl", control_word_out, 16'h037F);
    check("rst_tag",  tag_word_out, 16'hFFFF);
    check("rst_irq",  {15'd0, irq_out}, 16'h0000);
    reset = 1'b0;
    idle();

    // Masked exception read-back and held-strobe ack pattern
    status_word_in = 16'h1800;
    exc_pulse_in = 6'h01;
    idle();
    exc_pulse_in = 6'h00;
    bus_if.cs = 1'b1; bus_if.data_m_access = 1'b1;
    bus_if.data_m_wr_en = 1'b0; bus_if.data_m_addr = 2'd0;
    step();
    check("rd_status_1801", bus_if.data_m_data_out, 16'h1801);
    check("held_ack_1", {15'd0, bus_if.data_m_ack}, 16'h0001);
    step();
    check("held_ack_0", {15'd0, bus_if.data_m_ack}, 16'h0000);
    step();
    check("held_ack_1b", {15'd0, bus_if.data_m_ack}, 16'h0001);
    idle();
    check("irq_masked", {15'd0, irq_out}, 16'h0000);

    // Unmask IE: ES set, interrupt raised, then cleared by W1C
    status_word_in = 16'h0000;
    bus_op(1'b1, 2'd1, 2'b11, 16'h0360);
    check("ctrl_0360", control_word_out, 16'h0360);
    bus_op(1'b0, 2'd0, 2'b00, 16'h0000);
    check("rd_status_0081", bus_if.data_m_data_out, 16'h0081);
    check("irq_set", {15'd0, irq_out}, 16'h0001);
    bus_op(1'b1, 2'd0, 2'b01, 16'h0001);
    check("irq_clr", {15'd0, irq_out}, 16'h0000);

    // Same-cycle exception and W1C on one bit: the event wins
    exc_pulse_in = 6'h04;
    bus_if.cs = 1'b1; bus_if.data_m_access = 1'b1; bus_if.data_m_wr_en = 1'b1;
    bus_if.data_m_addr = 2'd0; bus_if.data_m_bytesel = 2'b01; bus_if.data_m_data_in = 16'h0004;
    step();
    exc_pulse_in = 6'h00;
    idle();
    bus_op(1'b0, 2'd0, 2'b00, 16'h0000);
    check("set_beats_w1c", bus_if.data_m_data_out, 16'h0084);

    // Byte-masked tag write, then fninit restores defaults
    bus_op(1'b1, 2'd2, 2'b01, 16'hABCD);
    check("tag_ffcd", tag_word_out, 16'hFFCD);
    fninit = 1'b1;
    idle();
    fninit = 1'b0;
    idle();
    check("fninit_tag",  tag_word_out, 16'hFFFF);
    check("fninit_ctrl", control_word_out, 16'h037F);
    bus_op(1'b0, 2'd0, 2'b00, 16'h0000);
    check("fninit_sticky", bus_if.data_m_data_out, 16'h0000);
    bus_op(1'b0, 2'd3, 2'b00, 16'h0000);
    check("addr3_zero", bus_if.data_m_data_out, 16'h0000);

    // Reset during a control write discards it
    bus_op(1'b1, 2'd1, 2'b11, 16'h1234);
    reset = 1'b1;
    bus_if.cs = 1'b1; bus_if.data_m_access = 1'b1; bus_if.data_m_wr_en = 1'b1;
    bus_if.data_m_addr = 2'd1; bus_if.data_m_bytesel = 2'b11; bus_if.data_m_data_in = 16'h5678;
    step();
    check("rst_mid_ack",  {15'd0, bus_if.data_m_ack}, 16'h0000);
    check("rst_mid_ctrl", control_word_out, 16'h037F);
    reset = 1'b0;
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset                 = ($urandom_range(0, 199) == 0);
      fninit                = ($urandom_range(0, 39) == 0);
      exc_pulse_in          = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      status_word_in        = 16'($urandom);
      bus_if.cs             = ($urandom_range(0, 3) != 0);
      bus_if.data_m_access  = ($urandom_range(0, 2) != 0);
      bus_if.data_m_wr_en   = 1'($urandom);
      bus_if.data_m_addr    = 2'($urandom);
      bus_if.data_m_bytesel = 2'($urandom);
      bus_if.data_m_data_in = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
